qam_mapper_pipe: RTL and testbench

QAM_MAPPER_PIPE -- requirements
Module: qam_mapper_pipe

---
 rtl/qam_mapper_pipe_if.sv | 46 ++++
 rtl/qam_mapper_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_qam_mapper_pipe.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_mapper_pipe_if.sv
// Streaming sink/source bundle for the QAM mapper.
// Master drives the sink side and consumes the source side.
interface qam_mapper_pipe_if #(
  parameter int LANES         = 4,
  parameter int MOD_OUT_WIDTH = 8
);
  logic [LANES*6-1:0]               asi_in0_data;
  logic                             asi_in0_valid;
  logic                             asi_in0_ready;
  logic                             asi_in0_startofpacket;
  logic                             asi_in0_endofpacket;
  logic [LANES*2*MOD_OUT_WIDTH-1:0] aso_out0_data;
  logic                             aso_out0_valid;
  logic                             aso_out0_ready;
  logic                             aso_out0_startofpacket;
  logic                             aso_out0_endofpacket;
  logic                             aso_out0_error;

  modport master (
    output asi_in0_data,
    output asi_in0_valid,
    input  asi_in0_ready,
    output asi_in0_startofpacket,
    output asi_in0_endofpacket,
    input  aso_out0_data,
    input  aso_out0_valid,
    output aso_out0_ready,
    input  aso_out0_startofpacket,
    input  aso_out0_endofpacket,
    input  aso_out0_error
  );

  modport slave (
    input  asi_in0_data,
    input  asi_in0_valid,
    output asi_in0_ready,
    input  asi_in0_startofpacket,
    input  asi_in0_endofpacket,
    output aso_out0_data,
    output aso_out0_valid,
    input  aso_out0_ready,
    output aso_out0_startofpacket,
    output aso_out0_endofpacket,
    output aso_out0_error
  );
endinterface

// File: rtl/qam_mapper_pipe.sv
// Two-stage Gray-coded 4/16/64-QAM mapper with packet-mode latching.
// S1 registers symbols and packet flags, S2 registers mapped I/Q.
module qam_mapper_pipe #(
  parameter int         LANES         = 4,
  parameter int         MOD_OUT_WIDTH = 8,
  parameter logic [1:0] RESET_MODE    = 2'b00
) (
  input  logic               clock_clk,
  input  logic               reset_reset,
  input  logic [1:0]         cfg_mode,
  qam_mapper_pipe_if.slave   bus,
  output logic [31:0]        stat_beat_count,
  output logic [15:0]        stat_err_count
);

  localparam int W  = MOD_OUT_WIDTH;
  localparam int SW = LANES * 6;
  localparam int DW = LANES * 2 * W;

  typedef enum logic {
    IDLE,
    IN_PKT
  } pkt_state_t;

  typedef struct packed {
    logic [SW-1:0] sym;
    logic [1:0]    mode;
    logic          sop;
    logic          eop;
    logic          err;
  } s1_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          err;
  } s2_t;

  pkt_state_t    state;
  logic [1:0]    pmode;
  logic          v1;
  logic          v2;
  s1_t           s1_q;
  s2_t           s2_q;
  logic [DW-1:0] mapped;
  logic          ld1;
  logic          ld2;
  logic          acc;
  logic          cons;

  assign ld2  = !v2 || bus.aso_out0_ready;
  assign ld1  = !v1 || ld2;
  assign acc  = bus.asi_in0_valid && ld1;
  assign cons = v2 && bus.aso_out0_ready;

  assign bus.asi_in0_ready = ld1;

  // Gray field -> level ((L-1)-2g) scaled by 2^(W-1)/L.
  function automatic logic [W-1:0] axis_level(
    input logic [1:0] mode,
    input logic [2:0] f
  );
    logic [2:0] g;
    logic [3:0] lm1;
    logic [3:0] m;
    logic [W-1:0] ext;
    int sh;
    g   = '0;
    lm1 = '0;
    sh  = 0;
    unique case (mode)
      2'b00: begin
        g   = {2'b00, f[0]};
        lm1 = 4'd1;
        sh  = W - 2;
      end
      2'b01: begin
        g   = {1'b0, f[1], f[1] ^ f[0]};
        lm1 = 4'd3;
        sh  = W - 3;
      end
      2'b10: begin
        g   = {f[2], f[2] ^ f[1], f[2] ^ f[1] ^ f[0]};
        lm1 = 4'd7;
        sh  = W - 4;
      end
      default: begin
        g   = '0;
        lm1 = '0;
        sh  = 0;
      end
    endcase
    m   = lm1 - {g, 1'b0};
    ext = {{(W-4){m[3]}}, m};
    return ext << sh;
  endfunction

  // Low half of the symbol bits drives I, upper half drives Q.
  function automatic logic [2*W-1:0] lane_map(
    input logic [1:0] mode,
    input logic [5:0] s
  );
    logic [2:0] fi;
    logic [2:0] fq;
    fi = '0;
    fq = '0;
    unique case (mode)
      2'b00: begin
        fi = {2'b00, s[0]};
        fq = {2'b00, s[1]};
      end
      2'b01: begin
        fi = {1'b0, s[1:0]};
        fq = {1'b0, s[3:2]};
      end
      2'b10: begin
        fi = s[2:0];
        fq = s[5:3];
      end
      default: begin
        fi = '0;
        fq = '0;
      end
    endcase
    if (mode == 2'b11) begin
      return '0;
    end
    return {axis_level(mode, fi), axis_level(mode, fq)};
  endfunction

  // Packet FSM and stage 1 share the accept strobe.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      v1    <= 1'b0;
      s1_q  <= '0;
      state <= IDLE;
      pmode <= RESET_MODE;
    end else if (ld1) begin
      v1 <= bus.asi_in0_valid;
      if (acc) begin
        s1_q.sym <= bus.asi_in0_data;
        s1_q.sop <= bus.asi_in0_startofpacket;
        s1_q.eop <= bus.asi_in0_endofpacket;
        unique case (1'b1)
          bus.asi_in0_startofpacket: begin
            pmode     <= cfg_mode;
            s1_q.mode <= cfg_mode;
            s1_q.err  <= (cfg_mode == 2'b11);
            state     <= bus.asi_in0_endofpacket ? IDLE : IN_PKT;
          end
          (!bus.asi_in0_startofpacket && state == IN_PKT): begin
            s1_q.mode <= pmode;
            s1_q.err  <= (pmode == 2'b11);
            if (bus.asi_in0_endofpacket) begin
              state <= IDLE;
            end
          end
          (!bus.asi_in0_startofpacket && state == IDLE): begin
            s1_q.mode <= pmode;
            s1_q.err  <= 1'b1;
          end
          default: begin
            s1_q.mode <= pmode;
            s1_q.err  <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    mapped = '0;
    for (int i = 0; i < LANES; i++) begin
      mapped[i*2*W +: 2*W] = lane_map(s1_q.mode, s1_q.sym[i*6 +: 6]);
    end
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      v2   <= 1'b0;
      s2_q <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_q.data <= mapped;
        s2_q.sop  <= s1_q.sop;
        s2_q.eop  <= s1_q.eop;
        s2_q.err  <= s1_q.err;
      end
    end
  end

  assign bus.aso_out0_valid         = v2;
  assign bus.aso_out0_data          = s2_q.data;
  assign bus.aso_out0_startofpacket = s2_q.sop;
  assign bus.aso_out0_endofpacket   = s2_q.eop;
  assign bus.aso_out0_error         = s2_q.err;

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      stat_beat_count <= '0;
      stat_err_count  <= '0;
    end else if (cons) begin
      stat_beat_count <= stat_beat_count + 32'd1;
      if (s2_q.err && stat_err_count != 16'hFFFF) begin
        stat_err_count <= stat_err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_qam_mapper_pipe.sv
// Randomised and directed checks of qam_mapper_pipe against
// an arithmetic QAM reference and a beat scoreboard.
module tb_qam_mapper_pipe;

  localparam int LANES = 4;
  localparam int W     = 8;
  localparam int SW    = LANES * 6;
  localparam int DW    = LANES * 2 * W;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [31:0] stat_beat_count;
  logic [15:0] stat_err_count;

  qam_mapper_pipe_if #(.LANES(LANES), .MOD_OUT_WIDTH(W)) bus ();

  qam_mapper_pipe #(
    .LANES(LANES),
    .MOD_OUT_WIDTH(W),
    .RESET_MODE(2'b00)
  ) dut (
    .clock_clk(clk),
    .reset_reset(rst),
    .cfg_mode(cfg_mode),
    .bus(bus),
    .stat_beat_count(stat_beat_count),
    .stat_err_count(stat_err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors;
  int miscompares;

  exp_t q[$];
  bit         m_in_pkt;
  logic [1:0] m_mode;
  int         exp_beats;
  int         exp_errs;

  logic          acc;
  logic          rdy_s;
  logic          vld_s;
  logic [DW-1:0] data_s;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_axis(input int f, input int h);
    int L;
    int g;
    int b;
    L = 1 << h;
    g = 0;
    b = 0;
    for (int j = h - 1; j >= 0; j--) begin
      b = b ^ ((f >> j) & 1);
      g = g | (b << j);
    end
    return W'(((L - 1) - 2 * g) * (1 << (W - 1)) / L);
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [1:0] m,
                                             input logic [SW-1:0] d);
    logic [DW-1:0] r;
    int h;
    int s;
    r = '0;
    if (m == 2'b11) return r;
    h = int'(m) + 1;
    for (int i = 0; i < LANES; i++) begin
      s = int'(d[i*6 +: 6]);
      r[i*2*W +: 2*W] = {ref_axis(s & ((1 << h) - 1), h),
                         ref_axis((s >> h) & ((1 << h) - 1), h)};
    end
    return r;
  endfunction

  task automatic model_accept(input logic [SW-1:0] d, input logic sop,
                              input logic eop, input logic [1:0] m);
    exp_t e;
    logic [1:0] em;
    if (sop) begin
      m_mode   = m;
      em       = m;
      e.err    = (m == 2'b11);
      m_in_pkt = !eop;
    end else if (m_in_pkt) begin
      em    = m_mode;
      e.err = (m_mode == 2'b11);
      if (eop) m_in_pkt = 1'b0;
    end else begin
      em    = m_mode;
      e.err = 1'b1;
    end
    e.data = ref_beat(em, d);
    e.sop  = sop;
    e.eop  = eop;
    q.push_back(e);
  endtask

  task automatic step(input logic v, input logic [SW-1:0] d,
                      input logic sop, input logic eop,
                      input logic [1:0] m, input logic ordy);
    exp_t e;
    logic cons;
    @(negedge clk);
    bus.asi_in0_valid         = v;
    bus.asi_in0_data          = d;
    bus.asi_in0_startofpacket = sop;
    bus.asi_in0_endofpacket   = eop;
    bus.aso_out0_ready        = ordy;
    cfg_mode                  = m;
    #1;
    rdy_s  = bus.asi_in0_ready;
    vld_s  = bus.aso_out0_valid;
    data_s = bus.aso_out0_data;
    acc    = v & rdy_s;
    cons   = vld_s & ordy;
    if (cons) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("beat_data", bus.aso_out0_data, e.data);
        chk("beat_flags",
            {61'd0, bus.aso_out0_startofpacket,
             bus.aso_out0_endofpacket, bus.aso_out0_error},
            {61'd0, e.sop, e.eop, e.err});
        exp_beats++;
        if (e.err && exp_errs != 16'hFFFF) exp_errs++;
      end
    end
    if (acc) model_accept(d, sop, eop, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.aso_out0_valid) && n < 20) begin
      idle(1);
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.asi_in0_valid = 1'b0;
    #1;
    chk("rst_ready", {63'd0, bus.asi_in0_ready}, 64'd1);
    chk("rst_valid", {63'd0, bus.aso_out0_valid}, 64'd0);
    q.delete();
    m_in_pkt  = 1'b0;
    m_mode    = 2'b00;
    exp_beats = 0;
    exp_errs  = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [SW-1:0] d;
    int            i;
    int            c;
    logic          sop;
    logic          eop;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    cfg_mode    = 2'b00;
    bus.asi_in0_valid         = 1'b0;
    bus.asi_in0_data          = '0;
    bus.asi_in0_startofpacket = 1'b0;
    bus.asi_in0_endofpacket   = 1'b0;
    bus.aso_out0_ready        = 1'b1;
    m_in_pkt  = 1'b0;
    m_mode    = 2'b00;
    exp_beats = 0;
    exp_errs  = 0;

    do_reset();
    #1;
    chk("reset_beats", 64'(stat_beat_count), 64'd0);
    chk("reset_errs", 64'(stat_err_count), 64'd0);
    chk("reset_data", bus.aso_out0_data, 64'd0);
    chk("reset_flags",
        {61'd0, bus.aso_out0_startofpacket, bus.aso_out0_endofpacket,
         bus.aso_out0_error}, 64'd0);

    // 4-QAM legacy constellation and two-cycle latency
    step(1'b1, {6'b000010, 6'b000011, 6'b000001, 6'b000000},
         1'b1, 1'b1, 2'b00, 1'b1);
    idle(1);
    chk("lat_early", {63'd0, vld_s}, 64'd0);
    idle(1);
    chk("lat_valid", {63'd0, vld_s}, 64'd1);
    chk("qam4_word", data_s, 64'h40C0_C0C0_C040_4040);
    drain();

    // 64-QAM pair
    step(1'b1, {18'($urandom), 6'b000010}, 1'b1, 1'b0, 2'b10, 1'b1);
    step(1'b1, {6'b100100, 6'b100100, 6'b100100, 6'b100100},
         1'b0, 1'b1, 2'b10, 1'b1);
    idle(2);
    chk("qam64_neg", data_s, 64'h9090_9090_9090_9090);
    drain();

    // mid-packet cfg change ignored
    step(1'b1, SW'($urandom), 1'b1, 1'b0, 2'b01, 1'b1);
    step(1'b1, SW'($urandom), 1'b0, 1'b0, 2'b10, 1'b1);
    step(1'b1, SW'($urandom), 1'b0, 1'b1, 2'b10, 1'b1);
    drain();

    // 10-beat stream with a 5-cycle downstream stall
    do_reset();
    i = 0;
    c = 0;
    while (i < 10 && c < 60) begin
      step(1'b1, SW'($urandom), i == 0, i == 9, 2'b01,
           !(c >= 3 && c < 8));
      if (c >= 5 && c < 8) chk("stall_ready", {63'd0, rdy_s}, 64'd0);
      if (acc) i++;
      c++;
    end
    chk("stream_accepted", 64'(i), 64'd10);
    drain();
    chk("stream_beats", 64'(stat_beat_count), 64'd10);
    chk("stream_errs", 64'(stat_err_count), 64'd0);

    // orphan beat in IDLE then reserved-mode packet
    do_reset();
    step(1'b1, SW'($urandom), 1'b0, 1'b0, 2'b01, 1'b1);
    step(1'b1, SW'($urandom), 1'b1, 1'b0, 2'b11, 1'b1);
    step(1'b1, SW'($urandom), 1'b0, 1'b1, 2'b00, 1'b1);
    drain();
    chk("err_count3", 64'(stat_err_count), 64'd3);
    chk("beat_count3", 64'(stat_beat_count), 64'd3);

    // reset with two beats in flight
    step(1'b1, SW'($urandom), 1'b1, 1'b0, 2'b01, 1'b1);
    step(1'b1, SW'($urandom), 1'b0, 1'b0, 2'b01, 1'b1);
    @(negedge clk);
    bus.asi_in0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, bus.aso_out0_valid}, 64'd0);
    chk("midrst_beats", 64'(stat_beat_count), 64'd0);
    chk("midrst_errs", 64'(stat_err_count), 64'd0);
    q.delete();
    m_in_pkt  = 1'b0;
    m_mode    = 2'b00;
    exp_beats = 0;
    exp_errs  = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("midrst_quiet", 64'(stat_beat_count), 64'd0);
    step(1'b1, SW'($urandom), 1'b1, 1'b0, 2'b10, 1'b1);
    step(1'b1, SW'($urandom), 1'b0, 1'b1, 2'b10, 1'b1);
    drain();
    chk("post_rst_beats", 64'(stat_beat_count), 64'd2);

    // random traffic with random backpressure
    do_reset();
    for (int n = 0; n < 400; n++) begin
      d   = SW'({$urandom, $urandom});
      sop = ($urandom_range(0, 3) == 0);
      eop = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 3) != 0, d, sop, eop,
           2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end
    drain();
    chk("rand_beats", 64'(stat_beat_count), 64'(exp_beats));
    chk("rand_errs", 64'(stat_err_count), 64'(exp_errs));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
